udp_tx_frame_buffer: RTL and testbench
======================================

UDP_TX_FRAME_BUFFER -- requirements
Module: udp_tx_frame_buffer

Interface
REQ-001 Parameter DATA_W, default 32, stream data width in bits; multiple of 8, range 8..128.
REQ-002 Parameter NUM_SLOTS, default 2, frame slots; power of two, range 2..8.
REQ-003 Parameter SLOT_DEPTH, default 256, words per slot; power of two, range 16..1024.
REQ-004 The block SHALL be clocked by aclk; reset aresetn SHALL be synchronous, active-low.
REQ-005 Ports (name direction width meaning):
- aclk  in  1  clock
- aresetn  in  1  synchronous active-low reset
- s_axis_tdata  in  DATA_W  payload in
- s_axis_tkeep  in  DATA_W/8  byte enables, valid on last beat only
- s_axis_tvalid / s_axis_tlast  in  1  AXIS in
- s_axis_tready  out  1  AXIS in
- m_axis_tdata  out  DATA_W  payload out
- m_axis_tkeep  out  DATA_W/8  byte enables out
- m_axis_tvalid / m_axis_tlast  out  1  AXIS out
- m_axis_tready  in  1  AXIS out
- eth_header_ip_tx_start  out  1  header request, level
- udp_header_tx_done  in  1  header finished, 1-cycle pulse
- udp_len  out  16  UDP length of head frame
- frames_pending  out  $clog2(NUM_SLOTS)+1  committed, unsent frames
- drop_cnt  out  16  dropped frames, saturating

Function
REQ-006 Slots SHALL be filled and drained in round-robin order; write and read slot pointers SHALL wrap NUM_SLOTS-1 -> 0.
REQ-007 Write FSM states: W_IDLE, W_DATA, W_DISCARD; W_IDLE -> W_DATA when the write slot is free.
REQ-008 s_axis_tready SHALL be 1 in W_DATA and W_DISCARD only; a beat is accepted on tvalid && tready.
REQ-009 An accepted beat SHALL be stored at word index 0..SLOT_DEPTH-1 of the write slot; the word counter SHALL increment per beat.
REQ-010 On the accepted tlast beat the slot SHALL commit: byte count = (words-1)*(DATA_W/8) + popcount(s_axis_tkeep); last-beat tkeep stored; frames_pending +1 next cycle; write pointer advances; FSM -> W_IDLE.
REQ-011 A single-beat frame (tlast on first beat) SHALL be valid; s_axis_tkeep SHALL be ignored on non-last beats.
REQ-012 Read FSM states: R_IDLE, R_HDR, R_DATA; R_IDLE -> R_HDR when frames_pending != 0.
REQ-013 In R_HDR eth_header_ip_tx_start SHALL be 1 and udp_len SHALL equal head-slot byte count + 8, stable until udp_header_tx_done.
REQ-014 On udp_header_tx_done in R_HDR: start deasserts next cycle; FSM -> R_DATA; m_axis_tvalid asserts no later than 2 cycles after the pulse.
REQ-015 udp_header_tx_done outside R_HDR SHALL be ignored.
REQ-016 m_axis_tvalid, tdata, tkeep, tlast SHALL hold while tvalid && !tready; with tready held high, beats SHALL be back-to-back without bubbles.
REQ-017 m_axis_tkeep SHALL be all ones except on the tlast beat, where it equals the stored last-beat tkeep; m_axis_tlast SHALL coincide with the final word.
REQ-018 On the final-beat handshake the slot SHALL be freed, frames_pending -1, read pointer advances, FSM -> R_IDLE.
REQ-019 A commit and a release in the same cycle SHALL leave frames_pending unchanged.
REQ-020 With all slots full s_axis_tready SHALL stay 0 until a slot frees; no data SHALL be lost or overwritten.
REQ-021 A beat arriving when word counter = SLOT_DEPTH (oversize frame) SHALL be handled per REQ-026/REQ-027.

Reset
REQ-022 While aresetn = 0: all FSMs idle; pointers, counters, frames_pending, drop_cnt = 0; s_axis_tready, m_axis_tvalid, m_axis_tlast, eth_header_ip_tx_start = 0; udp_len = 0; m_axis_tdata/tkeep = 0.
REQ-023 Reset mid-frame SHALL discard all stored and partial frames; the first frame after reset SHALL be written to slot 0.
REQ-024 Memory contents SHALL need no reset.

Configuration
REQ-025 Macro UDP_TX_DROP_OVERSIZE_EN SHALL select oversize handling.
REQ-026 Defined: on an oversize beat FSM -> W_DISCARD; remaining beats accepted and discarded through tlast; slot not committed; drop_cnt +1 (saturate at 0xFFFF).
REQ-027 Undefined: oversize beats accepted and discarded through tlast; slot committed with SLOT_DEPTH words, last stored tkeep all ones; drop_cnt stays 0.

Verification
REQ-028 32-bit, one 4-beat frame, last tkeep=0x3 -> start=1, udp_len=22; after done, 4 beats, last tkeep=0x3.
REQ-029 Three 10-beat frames back-to-back, NUM_SLOTS=2, done withheld -> third frame stalls with tready=0 and frames_pending=2; after done, all 30 words out in order.
REQ-030 Single-beat frame, tkeep=0xF -> udp_len=12, one beat with tvalid and tlast both 1.
REQ-031 Random m_axis_tready toggling over 256-beat frame -> output matches input, no duplicates or gaps.
REQ-032 SLOT_DEPTH=16, 20-beat frame, macro defined -> drop_cnt=1, no start; undefined -> 16 beats sent, udp_len=72.
REQ-033 aresetn low mid-frame for 1 cycle, then a 2-beat frame -> only the new frame is sent, frames_pending back to 0.

Source files
------------

// File: rtl/udp_tx_frame_buffer.sv
// Multi-slot UDP transmit frame buffer: stores AXIS frames, requests a header, then replays the payload.
// Macro UDP_TX_DROP_OVERSIZE_EN: drop oversize frames (counted) instead of committing them truncated.
module udp_tx_frame_buffer #(
    parameter int DATA_W     = 32,
    parameter int NUM_SLOTS  = 2,
    parameter int SLOT_DEPTH = 256
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic [DATA_W-1:0]            s_axis_tdata,
    input  logic [DATA_W/8-1:0]          s_axis_tkeep,
    input  logic                         s_axis_tvalid,
    input  logic                         s_axis_tlast,
    output logic                         s_axis_tready,
    output logic [DATA_W-1:0]            m_axis_tdata,
    output logic [DATA_W/8-1:0]          m_axis_tkeep,
    output logic                         m_axis_tvalid,
    output logic                         m_axis_tlast,
    input  logic                         m_axis_tready,
    output logic                         eth_header_ip_tx_start,
    input  logic                         udp_header_tx_done,
    output logic [15:0]                  udp_len,
    output logic [$clog2(NUM_SLOTS):0]   frames_pending,
    output logic [15:0]                  drop_cnt
);
    localparam int KW = DATA_W / 8;
    localparam int SW = $clog2(NUM_SLOTS);
    localparam int WW = $clog2(SLOT_DEPTH);
    localparam int CW = WW + 1;
    localparam logic [CW-1:0] DEPTH_W    = CW'(SLOT_DEPTH);
    localparam logic [SW:0]   FULL_CNT   = (SW+1)'(NUM_SLOTS);
    localparam logic [15:0]   FULL_BYTES = 16'(SLOT_DEPTH * KW);
`ifdef UDP_TX_DROP_OVERSIZE_EN
    localparam logic DROP_OVERSIZE = 1'b1;
`else
    localparam logic DROP_OVERSIZE = 1'b0;
`endif

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_DISCARD = 2'd2} wr_state_t;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_HDR = 2'd1, R_DATA = 2'd2} rd_state_t;

    wr_state_t         wr_state_r;
    rd_state_t         rd_state_r;
    logic [SW-1:0]     wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]     wcnt_r, rcnt_r;
    logic [SW:0]       pending_r;
    logic [15:0]       drop_cnt_r, udp_len_r;
    logic              s_tready_r, m_tvalid_r, m_tlast_r, hdr_start_r;
    logic [DATA_W-1:0] m_tdata_r;
    logic [KW-1:0]     m_tkeep_r;

    logic [DATA_W-1:0] mem [NUM_SLOTS*SLOT_DEPTH];
    logic [15:0]       slot_bytes [NUM_SLOTS];
    logic [CW-1:0]     slot_words [NUM_SLOTS];
    logic [KW-1:0]     slot_keep  [NUM_SLOTS];

    logic              accept_s, oversize_s, wr_en_s, commit_s, drop_s, release_s, nxt_last_s;
    logic [15:0]       c_bytes_s;
    logic [CW-1:0]     c_words_s, nxt_idx_s, head_words_s;
    logic [KW-1:0]     c_keep_s, nxt_keep_s;
    logic [DATA_W-1:0] rd_data_s;

    function automatic logic [15:0] popcount(input logic [KW-1:0] k);
        logic [15:0] c;
        c = 16'd0;
        for (int i = 0; i < KW; i++) c = c + {15'd0, k[i]};
        return c;
    endfunction

    assign s_axis_tready          = s_tready_r;
    assign m_axis_tdata           = m_tdata_r;
    assign m_axis_tkeep           = m_tkeep_r;
    assign m_axis_tvalid          = m_tvalid_r;
    assign m_axis_tlast           = m_tlast_r;
    assign eth_header_ip_tx_start = hdr_start_r;
    assign udp_len                = udp_len_r;
    assign frames_pending         = pending_r;
    assign drop_cnt               = drop_cnt_r;

    // Write-side decode: store enable, commit metadata and drop event for the current beat.
    always_comb begin
        accept_s   = s_axis_tvalid && s_tready_r;
        oversize_s = (wcnt_r == DEPTH_W);
        wr_en_s    = accept_s && (wr_state_r == W_DATA) && !oversize_s;
        drop_s     = DROP_OVERSIZE && accept_s && (wr_state_r == W_DATA) && oversize_s;
        commit_s   = 1'b0;
        c_bytes_s  = FULL_BYTES;
        c_words_s  = DEPTH_W;
        c_keep_s   = '1;
        case (wr_state_r)
            W_DATA: begin
                if (accept_s && s_axis_tlast && !oversize_s) begin
                    commit_s  = 1'b1;
                    c_words_s = wcnt_r + CW'(1);
                    c_bytes_s = 16'(wcnt_r) * 16'(KW) + popcount(s_axis_tkeep);
                    c_keep_s  = s_axis_tkeep;
                end else if (accept_s && s_axis_tlast) begin
                    commit_s = !DROP_OVERSIZE;
                end else begin
                    commit_s = 1'b0;
                end
            end
            W_DISCARD: begin
                if (accept_s && s_axis_tlast) begin
                    commit_s = !DROP_OVERSIZE;
                end else begin
                    commit_s = 1'b0;
                end
            end
            default: commit_s = 1'b0;
        endcase
    end

    // Read-side decode: next word to present and whether the final beat is being taken.
    always_comb begin
        head_words_s = slot_words[rd_ptr_r];
        nxt_idx_s    = (rd_state_r == R_HDR) ? '0 : rcnt_r;
        nxt_last_s   = (nxt_idx_s == head_words_s - CW'(1));
        nxt_keep_s   = nxt_last_s ? slot_keep[rd_ptr_r] : '1;
        rd_data_s    = mem[{rd_ptr_r, nxt_idx_s[WW-1:0]}];
        release_s    = (rd_state_r == R_DATA) && m_tvalid_r && m_axis_tready && m_tlast_r;
    end

    // Payload storage and per-slot metadata; contents are only read after a commit, so no reset.
    always_ff @(posedge aclk) begin
        if (wr_en_s) mem[{wr_ptr_r, wcnt_r[WW-1:0]}] <= s_axis_tdata;
        if (commit_s) begin
            slot_bytes[wr_ptr_r] <= c_bytes_s;
            slot_words[wr_ptr_r] <= c_words_s;
            slot_keep[wr_ptr_r]  <= c_keep_s;
        end
    end

    // Write FSM: wait for a free slot, fill it, discard any oversize tail.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_state_r <= W_IDLE;
            wr_ptr_r   <= '0;
            wcnt_r     <= '0;
            s_tready_r <= 1'b0;
            drop_cnt_r <= 16'd0;
        end else begin
            if (drop_s && drop_cnt_r != 16'hFFFF) drop_cnt_r <= drop_cnt_r + 16'd1;
            case (wr_state_r)
                W_IDLE: begin
                    if (pending_r != FULL_CNT) begin
                        wr_state_r <= W_DATA;
                        s_tready_r <= 1'b1;
                        wcnt_r     <= '0;
                    end
                end
                W_DATA, W_DISCARD: begin
                    if (accept_s && s_axis_tlast) begin
                        wr_state_r <= W_IDLE;
                        s_tready_r <= 1'b0;
                        if (commit_s) wr_ptr_r <= wr_ptr_r + SW'(1);
                    end else if (accept_s && oversize_s) begin
                        wr_state_r <= W_DISCARD;
                    end else if (accept_s) begin
                        wcnt_r <= wcnt_r + CW'(1);
                    end
                end
                default: begin
                    wr_state_r <= W_IDLE;
                    s_tready_r <= 1'b0;
                end
            endcase
        end
    end

    // Read FSM: request the header for the head slot, then stream its words out.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rd_state_r  <= R_IDLE;
            rd_ptr_r    <= '0;
            rcnt_r      <= '0;
            hdr_start_r <= 1'b0;
            udp_len_r   <= 16'd0;
            m_tvalid_r  <= 1'b0;
            m_tlast_r   <= 1'b0;
            m_tdata_r   <= '0;
            m_tkeep_r   <= '0;
        end else begin
            case (rd_state_r)
                R_IDLE: begin
                    if (pending_r != '0) begin
                        rd_state_r  <= R_HDR;
                        hdr_start_r <= 1'b1;
                        udp_len_r   <= slot_bytes[rd_ptr_r] + 16'd8;
                    end
                end
                R_HDR: begin
                    if (udp_header_tx_done) begin
                        rd_state_r  <= R_DATA;
                        hdr_start_r <= 1'b0;
                        m_tvalid_r  <= 1'b1;
                        m_tdata_r   <= rd_data_s;
                        m_tkeep_r   <= nxt_keep_s;
                        m_tlast_r   <= nxt_last_s;
                        rcnt_r      <= CW'(1);
                    end
                end
                R_DATA: begin
                    if (release_s) begin
                        rd_state_r <= R_IDLE;
                        m_tvalid_r <= 1'b0;
                        m_tlast_r  <= 1'b0;
                        rd_ptr_r   <= rd_ptr_r + SW'(1);
                    end else if (m_axis_tready) begin
                        m_tdata_r <= rd_data_s;
                        m_tkeep_r <= nxt_keep_s;
                        m_tlast_r <= nxt_last_s;
                        rcnt_r    <= rcnt_r + CW'(1);
                    end
                end
                default: rd_state_r <= R_IDLE;
            endcase
        end
    end

    // Committed-but-unsent frame count; simultaneous commit and release cancel out.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            pending_r <= '0;
        end else begin
            case ({commit_s, release_s})
                2'b10:   pending_r <= pending_r + (SW+1)'(1);
                2'b01:   pending_r <= pending_r - (SW+1)'(1);
                default: pending_r <= pending_r;
            endcase
        end
    end
endmodule

// File: tb/tb_udp_tx_frame_buffer.sv
// Directed testbench for udp_tx_frame_buffer (DATA_W=32, NUM_SLOTS=2, SLOT_DEPTH=256).
module tb_udp_tx_frame_buffer;
    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [31:0] s_axis_tdata = 32'd0;
    logic [3:0]  s_axis_tkeep = 4'd0;
    logic        s_axis_tvalid = 1'b0, s_axis_tlast = 1'b0, s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tvalid, m_axis_tlast;
    logic        m_axis_tready = 1'b0;
    logic        eth_header_ip_tx_start;
    logic        udp_header_tx_done = 1'b0;
    logic [15:0] udp_len, drop_cnt;
    logic [1:0]  frames_pending;
    int          nvec = 0;
    int          nerr = 0;

    udp_tx_frame_buffer #(.DATA_W(32), .NUM_SLOTS(2), .SLOT_DEPTH(256)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .eth_header_ip_tx_start(eth_header_ip_tx_start), .udp_header_tx_done(udp_header_tx_done),
        .udp_len(udp_len), .frames_pending(frames_pending), .drop_cnt(drop_cnt)
    );

    always #5 aclk = ~aclk;

    task automatic tick(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    // Pushes n beats base+i; tkeep is junk (0) on non-last beats; term=0 leaves the frame open.
    task automatic send_frame(input int n, input logic [31:0] base, input logic [3:0] lk, input bit term);
        bit acc;
        int guard;
        for (int i = 0; i < n; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = base + 32'(i);
            s_axis_tlast  = term && (i == n - 1);
            s_axis_tkeep  = (i == n - 1) ? lk : 4'h0;
            acc = 1'b0;
            guard = 0;
            while (!acc) begin
                @(negedge aclk);
                acc = s_axis_tready;
                tick(1);
                guard++;
                if (!acc && guard > 2000) begin
                    nvec++; nerr++;
                    $display("FAIL send_timeout beat=%0d got tready=0 want 1", i);
                    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
                    return;
                end
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic do_header(input logic [15:0] len);
        int guard = 0;
        while (!eth_header_ip_tx_start && guard < 1000) begin
            tick(1);
            guard++;
        end
        nvec++;
        if (eth_header_ip_tx_start !== 1'b1) begin
            nerr++; $display("FAIL hdr_start got %b want 1", eth_header_ip_tx_start);
            return;
        end
        nvec++;
        if (udp_len !== len) begin nerr++; $display("FAIL udp_len got %0d want %0d", udp_len, len); end
        tick(2);
        nvec++;
        if (eth_header_ip_tx_start !== 1'b1 || udp_len !== len) begin
            nerr++; $display("FAIL hdr_stable got start=%b len=%0d want 1/%0d", eth_header_ip_tx_start, udp_len, len);
        end
        udp_header_tx_done = 1'b1;
        tick(1);
        udp_header_tx_done = 1'b0;
        nvec++;
        if (eth_header_ip_tx_start !== 1'b0) begin nerr++; $display("FAIL hdr_deassert got %b want 0", eth_header_ip_tx_start); end
    endtask

    // Consumes n beats; rnd toggles tready randomly and checks output holds while stalled.
    task automatic recv_frame(input int n, input logic [31:0] base, input logic [3:0] lk, input bit rnd);
        int idx = 0, guard = 0;
        bit started = 1'b0, held = 1'b0, exp_last;
        logic [3:0]  exp_keep, h_keep;
        logic [31:0] h_data;
        logic        h_last;
        while (idx < n && guard < 5000) begin
            m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge aclk);
            if (held) begin
                nvec++;
                if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== h_data || m_axis_tkeep !== h_keep || m_axis_tlast !== h_last) begin
                    nerr++; $display("FAIL hold beat=%0d got %h/%h/%b want %h/%h/%b", idx, m_axis_tdata, m_axis_tkeep, m_axis_tlast, h_data, h_keep, h_last);
                end
            end
            held   = m_axis_tvalid && !m_axis_tready;
            h_data = m_axis_tdata; h_keep = m_axis_tkeep; h_last = m_axis_tlast;
            if (m_axis_tvalid && m_axis_tready) begin
                exp_last = (idx == n - 1);
                exp_keep = exp_last ? lk : 4'hF;
                nvec++;
                if (m_axis_tdata !== base + 32'(idx) || m_axis_tkeep !== exp_keep || m_axis_tlast !== exp_last) begin
                    nerr++; $display("FAIL beat %0d got %h/%h/%b want %h/%h/%b", idx, m_axis_tdata, m_axis_tkeep, m_axis_tlast, base + 32'(idx), exp_keep, exp_last);
                end
                idx++;
                started = 1'b1;
            end else if (!rnd && started) begin
                nvec++; nerr++;
                $display("FAIL bubble beat=%0d got tvalid=%b want 1", idx, m_axis_tvalid);
            end
            tick(1);
            guard++;
        end
        m_axis_tready = 1'b0;
        nvec++;
        if (idx != n) begin nerr++; $display("FAIL recv_count got %0d want %0d", idx, n); end
    endtask

    task automatic check_pending(input logic [1:0] want, input string tag);
        nvec++;
        if (frames_pending !== want) begin nerr++; $display("FAIL pending_%s got %0d want %0d", tag, frames_pending, want); end
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        tick(3);
        nvec++;
        if (s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || eth_header_ip_tx_start !== 1'b0) begin
            nerr++; $display("FAIL reset_ctl got %b%b%b%b want 0000", s_axis_tready, m_axis_tvalid, m_axis_tlast, eth_header_ip_tx_start);
        end
        nvec++;
        if (udp_len !== 16'd0 || drop_cnt !== 16'd0 || m_axis_tdata !== 32'd0 || m_axis_tkeep !== 4'd0) begin
            nerr++; $display("FAIL reset_data got %h/%h/%h/%h want 0/0/0/0", udp_len, drop_cnt, m_axis_tdata, m_axis_tkeep);
        end
        check_pending(2'd0, "reset");
        aresetn = 1'b1;
        tick(2);
        nvec++;
        if (s_axis_tready !== 1'b1) begin nerr++; $display("FAIL ready_after_reset got %b want 1", s_axis_tready); end
    endtask

    task automatic test_basic();
        send_frame(4, 32'h1000_0000, 4'h3, 1'b1);
        tick(1);
        check_pending(2'd1, "basic");
        do_header(16'd22);
        recv_frame(4, 32'h1000_0000, 4'h3, 1'b0);
        check_pending(2'd0, "basic_done");
    endtask

    task automatic test_single_beat();
        udp_header_tx_done = 1'b1;
        tick(1);
        udp_header_tx_done = 1'b0;
        tick(2);
        nvec++;
        if (eth_header_ip_tx_start !== 1'b0 || m_axis_tvalid !== 1'b0) begin
            nerr++; $display("FAIL stray_done got start=%b tvalid=%b want 0/0", eth_header_ip_tx_start, m_axis_tvalid);
        end
        send_frame(1, 32'h2000_0000, 4'hF, 1'b1);
        do_header(16'd12);
        recv_frame(1, 32'h2000_0000, 4'hF, 1'b0);
        check_pending(2'd0, "single");
    endtask

    task automatic test_back_to_back();
        fork
            begin
                send_frame(10, 32'h3000_0000, 4'hF, 1'b1);
                send_frame(10, 32'h3100_0000, 4'hF, 1'b1);
                send_frame(10, 32'h3200_0000, 4'hF, 1'b1);
            end
            begin
                tick(40);
                check_pending(2'd2, "full");
                nvec++;
                if (s_axis_tready !== 1'b0) begin nerr++; $display("FAIL full_stall got tready=%b want 0", s_axis_tready); end
                do_header(16'd48);
                recv_frame(10, 32'h3000_0000, 4'hF, 1'b0);
                do_header(16'd48);
                recv_frame(10, 32'h3100_0000, 4'hF, 1'b0);
                do_header(16'd48);
                recv_frame(10, 32'h3200_0000, 4'hF, 1'b0);
            end
        join
        check_pending(2'd0, "b2b_done");
    endtask

    task automatic test_random_ready();
        send_frame(256, 32'h4000_0000, 4'h7, 1'b1);
        do_header(16'd1031);
        recv_frame(256, 32'h4000_0000, 4'h7, 1'b1);
        check_pending(2'd0, "random");
    endtask

    task automatic test_oversize();
        send_frame(260, 32'h5000_0000, 4'h1, 1'b1);
`ifdef UDP_TX_DROP_OVERSIZE_EN
        tick(20);
        nvec++;
        if (drop_cnt !== 16'd1) begin nerr++; $display("FAIL drop_cnt got %0d want 1", drop_cnt); end
        nvec++;
        if (eth_header_ip_tx_start !== 1'b0) begin nerr++; $display("FAIL drop_nostart got %b want 0", eth_header_ip_tx_start); end
        check_pending(2'd0, "drop");
`else
        do_header(16'd1032);
        recv_frame(256, 32'h5000_0000, 4'hF, 1'b0);
        nvec++;
        if (drop_cnt !== 16'd0) begin nerr++; $display("FAIL drop_cnt got %0d want 0", drop_cnt); end
        check_pending(2'd0, "trunc");
`endif
    endtask

    task automatic test_reset_mid_frame();
        send_frame(2, 32'h6000_0000, 4'hF, 1'b1);
        send_frame(3, 32'h6100_0000, 4'hF, 1'b0);
        aresetn = 1'b0;
        tick(1);
        aresetn = 1'b1;
        nvec++;
        if (eth_header_ip_tx_start !== 1'b0 || s_axis_tready !== 1'b0) begin
            nerr++; $display("FAIL midreset got start=%b tready=%b want 0/0", eth_header_ip_tx_start, s_axis_tready);
        end
        check_pending(2'd0, "midreset");
        send_frame(2, 32'h7000_0000, 4'hC, 1'b1);
        do_header(16'd14);
        recv_frame(2, 32'h7000_0000, 4'hC, 1'b0);
        tick(5);
        check_pending(2'd0, "midreset_done");
        nvec++;
        if (eth_header_ip_tx_start !== 1'b0) begin nerr++; $display("FAIL stale_frame got start=%b want 0", eth_header_ip_tx_start); end
    endtask

    initial begin
        #1;
        test_reset();
        test_basic();
        test_single_beat();
        test_back_to_back();
        test_random_ready();
        test_oversize();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
